// File: rtl/airi5c_fpu_pkg.sv
// Shared FPU definitions: compare/min-max op encodings, canonical NaN,
// compare-stage FSM states, comparator flag bundle and NaN helpers.
package airi5c_fpu_pkg;

    // Op encodings for the compare/min-max stage; 5..7 are reserved.
    localparam logic [2:0] FPU_CMP_FEQ  = 3'd0;
    localparam logic [2:0] FPU_CMP_FLT  = 3'd1;
    localparam logic [2:0] FPU_CMP_FLE  = 3'd2;
    localparam logic [2:0] FPU_CMP_FMIN = 3'd3;
    localparam logic [2:0] FPU_CMP_FMAX = 3'd4;

    // RV32F canonical quiet NaN.
    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

    // Compare-stage sequencing.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Outcome of one float comparison. greater/equal/less are all zero
    // when the pair is unordered.
    typedef struct packed {
        logic greater;
        logic equal;
        logic less;
        logic unordered;
        logic a_nan;
        logic b_nan;
        logic a_snan;
        logic b_snan;
    } cmp_flags_t;

    // Exponent all ones with a non-zero fraction.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Signalling NaN: a NaN whose quiet bit (fraction MSB) is clear.
    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

endpackage

// File: rtl/airi5c_float_comparator_comb.sv
// Combinational IEEE-754 single-precision comparator. Orders two operands
// by sign-magnitude, treats +0 and -0 as equal, compares denormals exactly
// and reports NaN classes for the caller's exception logic.
module airi5c_float_comparator_comb
    import airi5c_fpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output cmp_flags_t  flags_o
);

    logic both_zero;
    logic eq_raw;
    logic lt_raw;

    // Derive ordering and NaN classification from the raw bit patterns.
    always_comb begin
        flags_o   = '0;
        both_zero = (a_i[30:0] == 31'd0) && (b_i[30:0] == 31'd0);
        eq_raw    = both_zero || (a_i == b_i);

        // Sign-magnitude ordering: opposite signs decide by sign unless both
        // are zeros; equal signs compare magnitudes, reversed when negative.
        if (a_i[31] != b_i[31]) begin
            lt_raw = a_i[31] && !both_zero;
        end else if (!a_i[31]) begin
            lt_raw = a_i[30:0] < b_i[30:0];
        end else begin
            lt_raw = a_i[30:0] > b_i[30:0];
        end

        flags_o.a_nan     = is_nan(a_i);
        flags_o.b_nan     = is_nan(b_i);
        flags_o.a_snan    = is_snan(a_i);
        flags_o.b_snan    = is_snan(b_i);
        flags_o.unordered = flags_o.a_nan || flags_o.b_nan;
        flags_o.equal     = !flags_o.unordered && eq_raw;
        flags_o.less      = !flags_o.unordered && lt_raw;
        flags_o.greater   = !flags_o.unordered && !eq_raw && !lt_raw;
    end

endmodule

// File: rtl/airi5c_float_compare_unit.sv
// Sequential compare/min-max stage for FEQ.S, FLT.S, FLE.S, FMIN.S, FMAX.S.
// Operands are captured on load, compared by the combinational comparator,
// and the RV32F result word plus NV flag are registered together with a
// one-cycle ready pulse.
//
// Handshake: load is sampled only while IDLE or DONE; a load seen while BUSY
// is dropped, so upstream must wait for ready before issuing the next op.
// ready is high for exactly the DONE cycle; result/NV hold until the next
// completed op. kill has priority over load and never updates result/NV.
module airi5c_float_compare_unit
    import airi5c_fpu_pkg::*;
#(
    parameter int unsigned REG_INPUTS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kill,
    input  logic        load,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        NV,
    output logic        ready,
    output fsm_state_e  dbg_state
);

    fsm_state_e  state_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        nv_q;
    logic        ready_q;

    logic [2:0]  op_sel;
    logic [31:0] a_sel;
    logic [31:0] b_sel;
    cmp_flags_t  flags;
    logic [31:0] result_d;
    logic        nv_d;
    logic        sig_nan;

    // Without the register stage the compare runs on the live inputs.
    assign op_sel = (REG_INPUTS != 0) ? op_q : op;
    assign a_sel  = (REG_INPUTS != 0) ? a_q  : a;
    assign b_sel  = (REG_INPUTS != 0) ? b_q  : b;

    airi5c_float_comparator_comb u_cmp (
        .a_i     (a_sel),
        .b_i     (b_sel),
        .flags_o (flags)
    );

    assign sig_nan = flags.a_snan || flags.b_snan;

    // Turn comparator flags into the RV32F result word and NV flag.
    always_comb begin
        result_d = 32'h0;
        nv_d     = 1'b0;
        case (op_sel)
            FPU_CMP_FEQ: begin
                result_d = {31'b0, flags.equal};
                nv_d     = sig_nan;
            end
            FPU_CMP_FLT: begin
                result_d = {31'b0, flags.less};
                nv_d     = flags.unordered;
            end
            FPU_CMP_FLE: begin
                result_d = {31'b0, flags.less || flags.equal};
                nv_d     = flags.unordered;
            end
            FPU_CMP_FMIN, FPU_CMP_FMAX: begin
                nv_d = sig_nan;
                if (flags.a_nan && flags.b_nan) begin
                    result_d = CANONICAL_NAN;
                end else if (flags.a_nan) begin
                    result_d = b_sel;
                end else if (flags.b_nan) begin
                    result_d = a_sel;
                end else if (flags.equal && (a_sel[31] != b_sel[31])) begin
                    // +0 vs -0: min picks the negative zero, max the positive.
                    if (op_sel == FPU_CMP_FMIN) begin
                        result_d = a_sel[31] ? a_sel : b_sel;
                    end else begin
                        result_d = a_sel[31] ? b_sel : a_sel;
                    end
                end else if (op_sel == FPU_CMP_FMIN) begin
                    result_d = flags.less ? a_sel : b_sel;
                end else begin
                    result_d = flags.greater ? a_sel : b_sel;
                end
            end
            default: begin
                result_d = 32'h0;
                nv_d     = 1'b0;
            end
        endcase
    end

    // Sequencing FSM with registered operands and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
            nv_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (kill) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (load) begin
                            op_q <= op;
                            a_q  <= a;
                            b_q  <= b;
                            if (REG_INPUTS != 0) begin
                                state_q <= ST_BUSY;
                            end else begin
                                state_q  <= ST_DONE;
                                result_q <= result_d;
                                nv_q     <= nv_d;
                                ready_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        state_q  <= ST_DONE;
                        result_q <= result_d;
                        nv_q     <= nv_d;
                        ready_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign result    = result_q;
    assign NV        = nv_q;
    assign ready     = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_airi5c_float_compare_unit.sv
// Directed, table-driven bench for the float compare/min-max stage.
module tb_airi5c_float_compare_unit;
    import airi5c_fpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        kill;
    logic        load;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        NV;
    logic        ready;
    fsm_state_e  dbg_state;

    int n_cmp;
    int n_fail;

    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_nv;
    } vec_t;

    vec_t vecs[22];

    airi5c_float_compare_unit #(.REG_INPUTS(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .load      (load),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .NV        (NV),
        .ready     (ready),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and wait (bounded) for ready; lat counts negedges after load.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        @(negedge clk);
        op = o; a = x; b = y; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat  = 1;
        while (!ready && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Watch n negedges and count ready pulses.
    task automatic count_ready(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] exp_r;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{"flt_1_lt_2",      FPU_CMP_FLT,  32'h3F800000, 32'h40000000, 32'h00000001, 1'b0};
        vecs[1]  = '{"feq_snan",        FPU_CMP_FEQ,  32'h7FA00000, 32'h3F800000, 32'h00000000, 1'b1};
        vecs[2]  = '{"feq_qnan",        FPU_CMP_FEQ,  32'h7FC00001, 32'h3F800000, 32'h00000000, 1'b0};
        vecs[3]  = '{"fle_qnan",        FPU_CMP_FLE,  32'h7FC00001, 32'h3F800000, 32'h00000000, 1'b1};
        vecs[4]  = '{"fmin_pz_nz",      FPU_CMP_FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0};
        vecs[5]  = '{"fmax_pz_nz",      FPU_CMP_FMAX, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0};
        vecs[6]  = '{"fmax_qnan_num",   FPU_CMP_FMAX, 32'h7FC00000, 32'hC0400000, 32'hC0400000, 1'b0};
        vecs[7]  = '{"fmin_two_nan",    FPU_CMP_FMIN, 32'h7F800001, 32'hFFC00000, 32'h7FC00000, 1'b1};
        vecs[8]  = '{"feq_pz_nz",       FPU_CMP_FEQ,  32'h00000000, 32'h80000000, 32'h00000001, 1'b0};
        vecs[9]  = '{"flt_neg",         FPU_CMP_FLT,  32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0};
        vecs[10] = '{"fle_equal",       FPU_CMP_FLE,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0};
        vecs[11] = '{"flt_equal",       FPU_CMP_FLT,  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0};
        vecs[12] = '{"fmax_mixed_sign", FPU_CMP_FMAX, 32'hBF800000, 32'h40000000, 32'h40000000, 1'b0};
        vecs[13] = '{"reserved_op5",    3'd5,         32'h3F800000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[14] = '{"fmin_denorm",     FPU_CMP_FMIN, 32'h00000002, 32'h00000001, 32'h00000001, 1'b0};
        vecs[15] = '{"flt_negden_pz",   FPU_CMP_FLT,  32'h80000001, 32'h00000000, 32'h00000001, 1'b0};
        vecs[16] = '{"fmax_infs",       FPU_CMP_FMAX, 32'hFF800000, 32'h7F800000, 32'h7F800000, 1'b0};
        vecs[17] = '{"fle_gt",          FPU_CMP_FLE,  32'h40000000, 32'h3F800000, 32'h00000000, 1'b0};
        vecs[18] = '{"fmin_nz_pz",      FPU_CMP_FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0};
        vecs[19] = '{"fmax_nz_pz",      FPU_CMP_FMAX, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[20] = '{"feq_qnan_qnan",   FPU_CMP_FEQ,  32'h7FC00000, 32'h7FC00000, 32'h00000000, 1'b0};
        vecs[21] = '{"flt_snan_snan",   FPU_CMP_FLT,  32'h7FA00000, 32'h7FA00000, 32'h00000000, 1'b1};

        // Reset.
        reset = 1'b1; kill = 1'b0; load = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        check32("reset_result", result, 32'h0);
        check32("reset_nv", {31'b0, NV}, 32'h0);
        check32("reset_ready", {31'b0, ready}, 32'h0);
        check32("reset_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        reset = 1'b0;
        @(negedge clk);

        // Table-driven ops.
        for (int i = 0; i < 22; i++) begin
            exp_q.push_back(vecs[i].exp_res);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            exp_r = exp_q.pop_front();
            check32({vecs[i].name, "_latency"}, lat, 32'd2);
            check32({vecs[i].name, "_result"}, result, exp_r);
            check32({vecs[i].name, "_nv"}, {31'b0, NV}, {31'b0, vecs[i].exp_nv});
        end
        // Last vector left result=0, NV=1.

        // Kill one cycle after load: no ready, outputs keep old values.
        @(negedge clk);
        op = FPU_CMP_FLT; a = 32'h3F800000; b = 32'h40000000; load = 1'b1;
        @(negedge clk);
        load = 1'b0; kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check32("kill_state_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        count_ready(4, pulses);
        check32("kill_no_ready", pulses, 32'd0);
        check32("kill_result_held", result, 32'h0);
        check32("kill_nv_held", {31'b0, NV}, 32'h1);

        // kill and load together: load dropped.
        op = FPU_CMP_FLT; a = 32'h3F800000; b = 32'h40000000; load = 1'b1; kill = 1'b1;
        @(negedge clk);
        load = 1'b0; kill = 1'b0;
        count_ready(4, pulses);
        check32("kill_load_no_ready", pulses, 32'd0);
        check32("kill_load_result_held", result, 32'h0);

        // Load while BUSY is ignored.
        op = FPU_CMP_FLT; a = 32'h3F800000; b = 32'h40000000; load = 1'b1;
        @(negedge clk);
        check32("busy_state", {30'b0, dbg_state}, {30'b0, ST_BUSY});
        op = FPU_CMP_FMAX; a = 32'h40400000; b = 32'h40000000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check32("busy_first_ready", {31'b0, ready}, 32'h1);
        check32("busy_first_result", result, 32'h1);
        count_ready(4, pulses);
        check32("busy_load_dropped", pulses, 32'd0);
        check32("busy_result_held", result, 32'h1);

        // Load issued in the DONE cycle: next ready two cycles later.
        do_op(FPU_CMP_FLT, 32'h40000000, 32'h3F800000, lat);
        check32("b2b_first_latency", lat, 32'd2);
        check32("b2b_first_result", result, 32'h0);
        op = FPU_CMP_FMAX; a = 32'h40400000; b = 32'h40000000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check32("b2b_gap_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        check32("b2b_second_ready", {31'b0, ready}, 32'h1);
        check32("b2b_second_result", result, 32'h40400000);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        op = FPU_CMP_FMIN; a = 32'h7FA00000; b = 32'h7FA00000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #1 reset = 1'b1;
        #1;
        check32("async_rst_result", result, 32'h0);
        check32("async_rst_nv", {31'b0, NV}, 32'h0);
        check32("async_rst_ready", {31'b0, ready}, 32'h0);
        check32("async_rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        @(negedge clk);
        reset = 1'b0;

        // Normal operation after reset.
        do_op(FPU_CMP_FLE, 32'hBF800000, 32'hBF800000, lat);
        check32("post_rst_latency", lat, 32'd2);
        check32("post_rst_result", result, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
